// File: rtl/rotate_sequencer_pkg.sv
// rotate_sequencer_pkg
//   Shared definitions for the rotate/shift register sequencer: default
//   widths and the 2-bit FSM state encoding (also used by the debug port).
package rotate_sequencer_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int STEPS_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rotate_sequencer_if.sv
// rotate_sequencer_if
//   Command side of the sequencer.
//   master (requester): drives start, data_in, steps, dir_right, arith, hold;
//                       observes busy, done.
//   slave  (sequencer): the reverse.
//
//   Handshake: start is a single-cycle strobe that is taken only while the
//   sequencer is idle (busy=0 and done=0); data_in/steps/dir_right/arith are
//   sampled on that same edge. A strobe seen while busy or during the done
//   cycle is dropped, not queued. done pulses for exactly one cycle when the
//   operation finishes; the next start may be presented in the cycle after.
interface rotate_sequencer_if
  import rotate_sequencer_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int STEPS_W = STEPS_W_DEF
) ();

  logic               start;
  logic [WIDTH-1:0]   data_in;
  logic [STEPS_W-1:0] steps;
  logic               dir_right;
  logic               arith;
  logic               hold;
  logic               busy;
  logic               done;

  modport master (
    output start, data_in, steps, dir_right, arith, hold,
    input  busy, done
  );

  modport slave (
    input  start, data_in, steps, dir_right, arith, hold,
    output busy, done
  );

endinterface

// File: rtl/rotate_sequencer_step_counter.sv
// step_counter
//   Loadable down-counter for the number of remaining shift cycles.
//   Ports:
//     clock, reset : rising-edge clock, synchronous active-high reset
//     load         : load load_value (has priority over dec)
//     load_value   : new count
//     dec          : decrement by one (saturates at zero)
//     count        : current count
//     last         : count == 1, i.e. this decrement is the final one
module step_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/rotate_sequencer.sv
// rotate_sequencer
//   Drives an external load/rotate/arithmetic-shift register: loads a value,
//   shifts it a requested number of cycles, then pulses done. The register
//   shifts every clock unless loaded, so between operations (and while held)
//   this block reloads the register with its own output.
//   Ports:
//     clock, reset      : rising-edge clock, synchronous active-high reset
//     cmd               : command interface (slave side), see rotate_sequencer_if
//     reg_q             : register contents fed back
//     reg_data          : register parallel-load data (combinational)
//     reg_loadn         : register load enable, active low
//     reg_rotate_right  : 1 = shift right, 0 = rotate left
//     reg_asright       : 1 = arithmetic right shift
//     state_dbg         : current FSM state
module rotate_sequencer
  import rotate_sequencer_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int STEPS_W = STEPS_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  rotate_sequencer_if.slave  cmd,
  input  logic [WIDTH-1:0]   reg_q,
  output logic [WIDTH-1:0]   reg_data,
  output logic               reg_loadn,
  output logic               reg_rotate_right,
  output logic               reg_asright,
  output state_t             state_dbg
);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   data_r;
  logic               dir_r;
  logic               arith_r;
  logic               accept;
  logic               cnt_dec;
  logic [STEPS_W-1:0] cnt;
  logic               cnt_last;

  assign accept = (state == ST_IDLE) && cmd.start;

  step_counter #(.W(STEPS_W)) u_step_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_value (cmd.steps),
    .dec        (cnt_dec),
    .count      (cnt),
    .last       (cnt_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      data_r  <= '0;
      dir_r   <= 1'b0;
      arith_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        data_r  <= cmd.data_in;
        dir_r   <= cmd.dir_right;
        // Arithmetic only has meaning for right shifts; masking here keeps
        // reg_asright from ever being set with a left rotate.
        arith_r <= cmd.arith & cmd.dir_right;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_dec  = 1'b0;
    case (state)
      ST_IDLE:  if (cmd.start) state_nx = ST_LOAD;
      ST_LOAD:  state_nx = (cnt == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: begin
        if (!cmd.hold) begin
          cnt_dec = 1'b1;
          if (cnt_last) state_nx = ST_DONE;
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Only SHIFT without hold lets the register shift; every other cycle it
  // is loaded, either with the new value (LOAD) or with itself (hold).
  assign reg_loadn        = (state == ST_SHIFT) && !cmd.hold;
  assign reg_data         = (state == ST_LOAD) ? data_r : reg_q;
  assign reg_rotate_right = (state == ST_SHIFT) && dir_r;
  assign reg_asright      = (state == ST_SHIFT) && arith_r;
  assign cmd.busy         = (state == ST_LOAD) || (state == ST_SHIFT);
  assign cmd.done         = (state == ST_DONE);
  assign state_dbg        = state;

endmodule

// File: tb/tb_rotate_sequencer.sv
// tb_rotate_sequencer
//   Pairs rotate_sequencer with a behavioural model of the rotating register
//   and checks final register values, done timing, busy length and hold/reset
//   behaviour.
module tb_rotate_sequencer;
  import rotate_sequencer_pkg::*;

  localparam int W  = 8;
  localparam int SW = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] reg_q;
  logic [W-1:0] reg_data;
  logic         reg_loadn;
  logic         reg_rotate_right;
  logic         reg_asright;
  state_t       state_dbg;
  logic         preset_en;
  logic [W-1:0] preset_val;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  // observations filled by drive_op
  int           obs_done_cyc;
  int           obs_busy_n;
  int           obs_done_n;
  logic         obs_loadn_hi;
  logic         obs_asr_viol;
  logic         obs_busy_after;
  logic [W-1:0] obs_reg_done;
  logic [W-1:0] obs_reg_after;

  rotate_sequencer_if #(.WIDTH(W), .STEPS_W(SW)) cmd_if ();

  rotate_sequencer #(.WIDTH(W), .STEPS_W(SW)) dut (
    .clock            (clock),
    .reset            (reset),
    .cmd              (cmd_if),
    .reg_q            (reg_q),
    .reg_data         (reg_data),
    .reg_loadn        (reg_loadn),
    .reg_rotate_right (reg_rotate_right),
    .reg_asright      (reg_asright),
    .state_dbg        (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- register model ----------------
  always @(posedge clock) begin
    if (preset_en)             reg_q <= preset_val;
    else if (!reg_loadn)       reg_q <= reg_data;
    else if (reg_rotate_right) reg_q <= {(reg_asright ? reg_q[W-1] : reg_q[0]), reg_q[W-1:1]};
    else                       reg_q <= {reg_q[W-2:0], reg_q[W-1]};
  end

  function automatic logic [W-1:0] model_result(logic [W-1:0] d, int n, logic right, logic ar);
    logic [W-1:0] v;
    v = d;
    for (int i = 0; i < n; i++) begin
      if (right) v = {((ar && right) ? v[W-1] : v[0]), v[W-1:1]};
      else       v = {v[W-2:0], v[W-1]};
    end
    return v;
  endfunction

  // ---------------- driver ----------------
  // Issues one command and follows it until done (bounded), then watches
  // 'post' further cycles. Cycle 1 is the cycle after start is sampled.
  task automatic drive_op(input logic [W-1:0] d, input int n, input logic right,
                          input logic ar, input int hold_at, input int hold_len,
                          input int inject_at, input int post);
    int cyc;
    obs_done_cyc = 0; obs_busy_n = 0; obs_done_n = 0;
    obs_loadn_hi = 1'b0; obs_asr_viol = 1'b0; obs_busy_after = 1'b0;
    obs_reg_done = 'x;
    @(posedge clock); #1;
    cmd_if.start     = 1'b1;
    cmd_if.data_in   = d;
    cmd_if.steps     = n[SW-1:0];
    cmd_if.dir_right = right;
    cmd_if.arith     = ar;
    cmd_if.hold      = 1'b0;
    @(posedge clock); #1;
    cmd_if.start = 1'b0;
    cyc = 1;
    while (cyc <= 60 && obs_done_cyc == 0) begin
      cmd_if.hold  = (hold_len > 0) && (cyc >= hold_at) && (cyc < hold_at + hold_len);
      cmd_if.start = (cyc == inject_at);
      if (cyc == inject_at) begin
        cmd_if.data_in = ~d;
        cmd_if.steps   = SW'($urandom_range(1, 15));
      end
      #1;
      if (cmd_if.busy) obs_busy_n++;
      if (reg_loadn) obs_loadn_hi = 1'b1;
      if (reg_asright && !reg_rotate_right) obs_asr_viol = 1'b1;
      if (cmd_if.done) begin
        obs_done_n++;
        obs_done_cyc = cyc;
        obs_reg_done = reg_q;
      end else begin
        @(posedge clock); #1;
        cyc++;
      end
    end
    cmd_if.start = 1'b0;
    cmd_if.hold  = 1'b0;
    for (int k = 0; k < post; k++) begin
      @(posedge clock); #2;
      if (cmd_if.busy) obs_busy_after = 1'b1;
      if (cmd_if.done) obs_done_n++;
    end
    obs_reg_after = reg_q;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    preset_en = 1'b1; preset_val = 8'hA5; reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 preset_en = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #2;
      n_vec++; if (reg_loadn !== 1'b0) begin n_err++; $display("FAIL reset_loadn cyc%0d: got %b want 0", i, reg_loadn); end
      n_vec++; if (reg_data !== 8'hA5) begin n_err++; $display("FAIL reset_reg_data cyc%0d: got %h want a5", i, reg_data); end
      n_vec++; if (reg_q !== 8'hA5) begin n_err++; $display("FAIL reset_reg_q cyc%0d: got %h want a5", i, reg_q); end
      n_vec++; if (cmd_if.busy !== 1'b0 || cmd_if.done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done cyc%0d: got %b%b want 00", i, cmd_if.busy, cmd_if.done); end
    end
    n_vec++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_right_rotate();
    logic [W-1:0] e;
    exp_q.push_back(8'hC0);
    drive_op(8'b1000_0001, 1, 1'b1, 1'b0, 0, 0, 0, 2);
    e = exp_q.pop_front();
    n_vec++; if (obs_reg_done !== e) begin n_err++; $display("FAIL rot1_reg: got %h want %h", obs_reg_done, e); end
    n_vec++; if (obs_done_cyc !== 3) begin n_err++; $display("FAIL rot1_done_cyc: got %0d want 3", obs_done_cyc); end
    n_vec++; if (obs_busy_n !== 2) begin n_err++; $display("FAIL rot1_busy: got %0d want 2", obs_busy_n); end
    n_vec++; if (obs_done_n !== 1) begin n_err++; $display("FAIL rot1_done_count: got %0d want 1", obs_done_n); end
    n_vec++; if (obs_reg_after !== e) begin n_err++; $display("FAIL rot1_reg_hold: got %h want %h", obs_reg_after, e); end
  endtask

  task automatic test_arith();
    logic [W-1:0] e;
    exp_q.push_back(8'hF0);
    drive_op(8'h80, 3, 1'b1, 1'b1, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_vec++; if (obs_reg_done !== e) begin n_err++; $display("FAIL asr3_reg: got %h want %h", obs_reg_done, e); end
    n_vec++; if (obs_done_cyc !== 5) begin n_err++; $display("FAIL asr3_done_cyc: got %0d want 5", obs_done_cyc); end
    exp_q.push_back(8'h03);
    drive_op(8'h81, 1, 1'b0, 1'b1, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_vec++; if (obs_reg_done !== e) begin n_err++; $display("FAIL left_arith_ignored_reg: got %h want %h", obs_reg_done, e); end
    n_vec++; if (obs_asr_viol !== 1'b0) begin n_err++; $display("FAIL asright_without_right: got %b want 0", obs_asr_viol); end
    exp_q.push_back(8'hFF);
    drive_op(8'hC3, 9, 1'b1, 1'b1, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_vec++; if (obs_reg_done !== e) begin n_err++; $display("FAIL asr9_saturate_reg: got %h want %h", obs_reg_done, e); end
  endtask

  task automatic test_wrap_and_zero();
    logic [W-1:0] e;
    exp_q.push_back(8'h3C);
    drive_op(8'h3C, 8, 1'b0, 1'b0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_vec++; if (obs_reg_done !== e) begin n_err++; $display("FAIL rot8_reg: got %h want %h", obs_reg_done, e); end
    n_vec++; if (obs_busy_n !== 9) begin n_err++; $display("FAIL rot8_busy: got %0d want 9", obs_busy_n); end
    n_vec++; if (obs_done_cyc !== 10) begin n_err++; $display("FAIL rot8_done_cyc: got %0d want 10", obs_done_cyc); end
    exp_q.push_back(8'h78);
    drive_op(8'h3C, 9, 1'b0, 1'b0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_vec++; if (obs_reg_done !== e) begin n_err++; $display("FAIL rot9_wrap_reg: got %h want %h", obs_reg_done, e); end
    exp_q.push_back(8'h5A);
    drive_op(8'h5A, 0, 1'b0, 1'b0, 0, 0, 0, 2);
    e = exp_q.pop_front();
    n_vec++; if (obs_reg_done !== e) begin n_err++; $display("FAIL zero_steps_reg: got %h want %h", obs_reg_done, e); end
    n_vec++; if (obs_done_cyc !== 2) begin n_err++; $display("FAIL zero_steps_done_cyc: got %0d want 2", obs_done_cyc); end
    n_vec++; if (obs_busy_n !== 1) begin n_err++; $display("FAIL zero_steps_busy: got %0d want 1", obs_busy_n); end
    n_vec++; if (obs_loadn_hi !== 1'b0) begin n_err++; $display("FAIL zero_steps_loadn: got %b want 0", obs_loadn_hi); end
  endtask

  task automatic test_hold();
    logic [W-1:0] e;
    exp_q.push_back(8'h10);
    drive_op(8'h01, 4, 1'b1, 1'b0, 3, 2, 4, 3);
    e = exp_q.pop_front();
    n_vec++; if (obs_reg_done !== e) begin n_err++; $display("FAIL hold_reg: got %h want %h", obs_reg_done, e); end
    n_vec++; if (obs_done_cyc !== 8) begin n_err++; $display("FAIL hold_done_cyc: got %0d want 8", obs_done_cyc); end
    n_vec++; if (obs_busy_n !== 7) begin n_err++; $display("FAIL hold_busy: got %0d want 7", obs_busy_n); end
    n_vec++; if (obs_done_n !== 1) begin n_err++; $display("FAIL hold_done_count: got %0d want 1", obs_done_n); end
    n_vec++; if (obs_busy_after !== 1'b0) begin n_err++; $display("FAIL hold_start_ignored: busy after done got %b want 0", obs_busy_after); end
  endtask

  task automatic test_start_in_done();
    logic [W-1:0] e;
    exp_q.push_back(8'hC3);
    drive_op(8'h0F, 2, 1'b1, 1'b0, 0, 0, 4, 3);
    e = exp_q.pop_front();
    n_vec++; if (obs_reg_done !== e) begin n_err++; $display("FAIL done_start_reg: got %h want %h", obs_reg_done, e); end
    n_vec++; if (obs_busy_after !== 1'b0) begin n_err++; $display("FAIL done_start_ignored: busy got %b want 0", obs_busy_after); end
    n_vec++; if (obs_done_n !== 1) begin n_err++; $display("FAIL done_start_count: got %0d want 1", obs_done_n); end
    n_vec++; if (obs_reg_after !== e) begin n_err++; $display("FAIL done_start_reg_after: got %h want %h", obs_reg_after, e); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e;
    logic         saw_done;
    saw_done = 1'b0;
    exp_q.push_back(8'h20);  // three right rotates of 01 before the abort
    @(posedge clock); #1;
    cmd_if.start = 1'b1; cmd_if.data_in = 8'h01; cmd_if.steps = 4'd6;
    cmd_if.dir_right = 1'b1; cmd_if.arith = 1'b0;
    @(posedge clock); #1 cmd_if.start = 1'b0;      // cycle 1
    for (int c = 1; c < 4; c++) begin
      #1 if (cmd_if.done) saw_done = 1'b1;
      @(posedge clock); #1;
    end
    reset = 1'b1;                                  // cycle 4 = 3rd SHIFT cycle
    @(posedge clock); #1 reset = 1'b0;             // cycle 5
    #1;
    n_vec++; if (cmd_if.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", cmd_if.busy); end
    n_vec++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL abort_state: got %0d want %0d", state_dbg, ST_IDLE); end
    for (int k = 0; k < 5; k++) begin
      if (cmd_if.done || cmd_if.busy) saw_done = 1'b1;
      @(posedge clock); #2;
    end
    e = exp_q.pop_front();
    n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
    n_vec++; if (reg_q !== e) begin n_err++; $display("FAIL abort_reg_frozen: got %h want %h", reg_q, e); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d, e;
    int           n;
    logic         right, ar;
    for (int t = 0; t < 6; t++) begin
      d = W'($urandom_range(0, 255));
      n = $urandom_range(0, 15);
      right = 1'($urandom_range(0, 1));
      ar = 1'($urandom_range(0, 1));
      exp_q.push_back(model_result(d, n, right, ar));
      drive_op(d, n, right, ar, 0, 0, 0, 0);
      e = exp_q.pop_front();
      n_vec++; if (obs_reg_done !== e) begin n_err++; $display("FAIL b2b%0d_reg d=%h n=%0d r=%b a=%b: got %h want %h", t, d, n, right, ar, obs_reg_done, e); end
      n_vec++; if (obs_done_cyc !== n + 2) begin n_err++; $display("FAIL b2b%0d_done_cyc: got %0d want %0d", t, obs_done_cyc, n + 2); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1; preset_en = 1'b0; preset_val = '0;
    cmd_if.start = 1'b0; cmd_if.data_in = '0; cmd_if.steps = '0;
    cmd_if.dir_right = 1'b0; cmd_if.arith = 1'b0; cmd_if.hold = 1'b0;
    test_reset();
    test_right_rotate();
    test_arith();
    test_wrap_and_zero();
    test_hold();
    test_start_in_done();
    test_reset_mid();
    test_back_to_back();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rotate_sequencer.md
# rotate_sequencer

Control sequencer for the team's 8-bit load/rotate/arithmetic-shift register. It accepts a start command with load data, a step count and a mode. It then drives the register's load-enable, direction and arithmetic-shift controls to load the value and shift it the requested number of positions, and signals completion with a one-cycle `done` pulse. The register shifts on every clock unless loaded, so this block holds it between operations by reloading its own output.

## Interface
Parameters:
- `WIDTH`, 8: register width; must match the controlled register.
- `STEPS_W`, 4: width of the step count (0..15 steps).

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `data_in`  in  WIDTH  value to load; sampled with `start`.
- `steps`  in  STEPS_W  number of shift cycles; sampled with `start`.
- `dir_right`  in  1  1 = shift right, 0 = rotate left; sampled with `start`.
- `arith`  in  1  1 = arithmetic right shift (MSB replicated); ignored when `dir_right`=0.
- `hold`  in  1  pauses the SHIFT state; the register is frozen and the count is not decremented.
- `reg_q`  in  WIDTH  current register contents, fed back.
- `reg_data`  out  WIDTH  register parallel-load data.
- `reg_loadn`  out  1  register load enable, active low.
- `reg_rotate_right`  out  1  register direction select.
- `reg_asright`  out  1  register arithmetic-shift select.
- `busy`  out  1  high in LOAD and SHIFT.
- `done`  out  1  one-cycle completion pulse.

## Operation
States:
- **IDLE**
  - Outputs: `reg_loadn`=0, `reg_data`=`reg_q` (hold), direction and arith outputs 0.
  - On `start`=1: latch `data_in`, `steps`, `dir_right` and `arith & dir_right`, then go to LOAD.
- **LOAD** (exactly 1 cycle)
  - Outputs: `reg_loadn`=0, `reg_data`=latched data.
  - Next state is SHIFT if latched steps ≠ 0, otherwise DONE.
- **SHIFT**
  - With `hold`=0:
    - Outputs: `reg_loadn`=1, `reg_rotate_right`=latched dir, `reg_asright`=latched arith.
    - Decrement the counter. When the counter goes 1→0, go to DONE.
  - With `hold`=1: outputs as in IDLE hold (`reg_loadn`=0, `reg_data`=`reg_q`), counter unchanged, state unchanged.
- **DONE** (exactly 1 cycle)
  - Outputs: `done`=1, `busy`=0, register held as in IDLE.
  - Next state: IDLE.

Rules:
- `reg_asright` is never 1 while `reg_rotate_right`=0.
- `start` outside IDLE (including during DONE) is ignored, not queued.
- Step count is unsigned.
  - Rotate by 8 returns the original value; rotate by more than 8 wraps.
  - Arithmetic shift by 7 or more saturates to all bits equal to the MSB.
- `reg_data` is combinational; `reg_loadn`, `reg_rotate_right`, `reg_asright`, `busy` and `done` decode from registered state only, with no input-to-output paths except `hold` in SHIFT.

## Timing
- Reset (synchronous, dominant over every other input):
  - Next cycle the state is IDLE, counter 0, latched fields 0.
  - `busy`=0, `done`=0, `reg_loadn`=0, `reg_rotate_right`=0, `reg_asright`=0, `reg_data`=`reg_q`.
- Reset mid-operation aborts the operation; no `done` pulse is produced. The register's own reset is separate and is not driven by this block.
- Latency with no holds: `start` sampled at edge 0 → LOAD in cycle 1 → SHIFT in cycles 2..N+1 → DONE in cycle N+2.
  - The register holds its final value at the DONE cycle, and from then on.
  - `busy` is high for N+1 cycles.
- Each cycle of `hold`=1 in SHIFT adds one cycle. `hold` outside SHIFT has no effect.
- Back-to-back operation: `start` is accepted again in the cycle after DONE.

## Structure
- Shared package or header holds:
  - state encodings (IDLE/LOAD/SHIFT/DONE, 2 bits)
  - `WIDTH` and `STEPS_W` defaults
- One natural sub-module, `step_counter`: a loadable down-counter with decrement enable and a `last` flag (count==1). The FSM and output decode stay in `rotate_sequencer`.
- The bench pairs the sequencer with a behavioural model of the rotating register (active-low load; right shift takes the MSB from the LSB, or from itself when arithmetic; left rotate).

## Test plan
- Reset, register preset to 8'hA5, no start for 10 cycles → `reg_loadn`=0, `reg_data`=8'hA5, register stays 8'hA5, `busy`=0, `done`=0.
- start, `data_in`=8'b1000_0001, `steps`=1, `dir_right`=1, `arith`=0 → register 8'b1100_0000; `done` pulses in cycle 3 after start; `busy` high for 2 cycles.
- start, `data_in`=8'h80, `steps`=3, right, `arith`=1 → register 8'hF0 at `done`. Repeat with `arith`=1, left, `data_in`=8'h81, `steps`=1 → 8'h03 (`arith` ignored).
- start, `data_in`=8'h3C, `steps`=8, left → register 8'h3C at `done`, `busy` for 9 cycles. Then `steps`=0, `data_in`=8'h5A → LOAD then DONE, register 8'h5A, `reg_loadn` never 1.
- `steps`=4, right, rotate, `data_in`=8'h01, `hold`=1 for 2 cycles mid-SHIFT → register 8'h10, `done` 2 cycles later than the unheld case. A `start` pulse while busy is ignored, and exactly one `done` pulse occurs.
- `steps`=6, reset asserted in the 3rd SHIFT cycle → IDLE next cycle, `busy`=0, no `done`, register frozen at its last value via reload.
